output_neuron_mac: RTL

OUTPUT_NEURON_MAC -- requirements
Module: output_neuron_mac

---
 rtl/output_neuron_mac_pkg.sv | 27 ++
 rtl/sat_shift_q511.sv | 29 ++
 rtl/output_neuron_mac.sv | 112 +++++++++++
 3 files changed

// File: rtl/output_neuron_mac_pkg.sv
// Shared Q5.11 constants for the neuron layers: widths, output-layer weights, bias and the
// sequencer state encoding.
package output_neuron_mac_pkg;

  localparam int unsigned N    = 16;
  localparam int unsigned FRAC = 11;
  localparam int unsigned K    = 4;

  localparam logic [N-1:0] Bias = 16'h0400;

  localparam logic [1:0] StCollect = 2'd0;
  localparam logic [1:0] StMac     = 2'd1;
  localparam logic [1:0] StBias    = 2'd2;
  localparam logic [1:0] StSat     = 2'd3;

  // Output-layer weights {1.0, -0.5, 0.25, 2.0}; indices past the table read as zero.
  function automatic logic [N-1:0] weight(input int unsigned idx);
    case (idx)
      0:       weight = 16'h0800;
      1:       weight = 16'hFC00;
      2:       weight = 16'h0200;
      3:       weight = 16'h1000;
      default: weight = '0;
    endcase
  endfunction

endpackage

// File: rtl/sat_shift_q511.sv
// Arithmetic right shift of the wide accumulator back to Q5.11 with saturation to the
// N-bit signed range.
module sat_shift_q511 #(
  parameter int unsigned AccW = 34,
  parameter int unsigned N    = 16,
  parameter int unsigned Frac = 11
) (
  input  logic signed [AccW-1:0] i_acc,
  output logic        [N-1:0]    o_res
);

  localparam logic signed [AccW-1:0] MaxVal = {{(AccW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AccW-1:0] MinVal = {{(AccW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [AccW-1:0] w_shifted;

  // Arithmetic shift floors toward minus infinity.
  assign w_shifted = i_acc >>> Frac;

  always_comb begin
    o_res = w_shifted[N-1:0];
    if (w_shifted > MaxVal) begin
      o_res = MaxVal[N-1:0];
    end else if (w_shifted < MinVal) begin
      o_res = MinVal[N-1:0];
    end
  end

endmodule

// File: rtl/output_neuron_mac.sv
// Output neuron: buffers K hidden activations, runs a sequential MAC against the fixed weights,
// adds the bias and emits a saturated Q5.11 result with a class bit and a one-cycle rdy pulse.
module output_neuron_mac #(
  parameter int unsigned N = output_neuron_mac_pkg::N,
  parameter int unsigned K = output_neuron_mac_pkg::K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         busy,
  output logic [N-1:0] res,
  output logic         cls,
  output logic         rdy
);

  import output_neuron_mac_pkg::*;

  localparam int unsigned AccW = 2 * N + $clog2(K);
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

  logic [1:0]             r_state;
  logic [CntW-1:0]        r_cnt;
  logic [CntW-1:0]        r_idx;
  logic signed [AccW-1:0] r_acc;
  logic signed [N-1:0]    r_buf [K];
  logic [N-1:0]           r_res;
  logic                   r_cls;
  logic                   r_rdy;

  logic                   w_last_in;
  logic                   w_last_mac;
  logic signed [N-1:0]    w_weight;
  logic signed [N-1:0]    w_bias;
  logic signed [2*N-1:0]  w_prod;
  logic signed [AccW-1:0] w_bias_ext;
  logic [N-1:0]           w_sat;

  assign w_last_in  = (r_cnt == CntW'(K - 1));
  assign w_last_mac = (r_idx == CntW'(K - 1));
  assign w_weight   = N'(weight(32'(r_idx)));
  assign w_bias     = N'(Bias);
  assign w_prod     = r_buf[r_idx] * w_weight;
  assign w_bias_ext = {{(AccW-N){w_bias[N-1]}}, w_bias} <<< FRAC;

  sat_shift_q511 #(
    .AccW(AccW),
    .N   (N),
    .Frac(FRAC)
  ) u_sat (
    .i_acc(r_acc),
    .o_res(w_sat)
  );

  // Buffer has no reset: every slot is written in COLLECT before MAC reads it.
  always_ff @(posedge clk) begin
    if (ena && in_valid && (r_state == StCollect)) begin
      r_buf[r_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StCollect;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_cls   <= 1'b0;
      r_rdy   <= 1'b0;
    end else if (ena) begin
      r_rdy <= 1'b0;
      case (r_state)
        StCollect: begin
          if (in_valid) begin
            r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
            if (w_last_in) begin
              r_state <= StMac;
              r_idx   <= '0;
              r_acc   <= '0;
            end
          end
        end
        StMac: begin
          r_acc <= r_acc + AccW'(w_prod);
          r_idx <= w_last_mac ? '0 : r_idx + 1'b1;
          if (w_last_mac) begin
            r_state <= StBias;
          end
        end
        StBias: begin
          r_acc   <= r_acc + w_bias_ext;
          r_state <= StSat;
        end
        StSat: begin
          r_res   <= w_sat;
          r_cls   <= ($signed(w_sat) > 0);
          r_rdy   <= 1'b1;
          r_state <= StCollect;
        end
        default: r_state <= StCollect;
      endcase
    end
  end

  assign busy = (r_state != StCollect);
  assign res  = r_res;
  assign cls  = r_cls;
  assign rdy  = r_rdy;

endmodule
